ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the ARM pipeline: the consumer of the ID/EX register bundle. Each cycle it selects operand B (register or extended immediate), performs the 2-bit ALU operation, evaluates the instruction's condition code against an internal NZCV flags register, optionally updates the flags, and registers the results into the EX/MEM bundle. A valid/stall handshake lets the MEM stage back-pressure EX, and EX in turn holds the ID/EX register.

## Interface
Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 4, register-file address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  ID/EX holds a real instruction.
- reg_write_enable_in  in  1  register write enable.
- mem_write_enable_in  in  1  memory write enable.
- mem_to_reg_select_in  in  1  writeback selects memory data.
- alu_src_select_in  in  1  0: operand B = rd2_in; 1: operand B = ext_imm_in.
- alu_control_in  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- set_flags_in  in  1  update NZCV on execution.
- cond_in  in  4  ARM condition code.
- rd1_in  in  DATA_W  operand A.
- rd2_in  in  DATA_W  register operand B and store data.
- ext_imm_in  in  DATA_W  extended immediate.
- write_addr_in  in  REG_ADDR_W  destination register.
- mem_stall_in  in  1  MEM cannot accept this cycle.
- ex_stall_out  out  1  combinational, equals valid_out AND mem_stall_in; ID/EX must hold.
- valid_out  out  1  EX/MEM holds an instruction.
- reg_write_enable_out, mem_write_enable_out, mem_to_reg_select_out  out  1 each  registered controls, write enables gated by the condition result.
- alu_result_out  out  DATA_W  ALU result.
- write_data_out  out  DATA_W  rd2_in captured for stores.
- write_addr_out  out  REG_ADDR_W  destination register.
- flags_out  out  4  current NZCV, with N as bit 3.

## Operation
- The stage accepts an instruction when valid_in=1 and ex_stall_out=0.
- ALU:
  - ADD: A+B, with C = carry out of bit 31 and V = signed overflow.
  - SUB: A−B, with C = NOT borrow (A ≥ B unsigned) and V = signed overflow.
  - AND and ORR: C and V are preserved.
  - All operations: N = result[31] and Z = (result==0).
- Conditions are evaluated against the flags register. Pass rules:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V); AL pass; 1111 pass (treated as AL).
- On acceptance:
  - Load all outputs and set valid_out=1.
  - If the condition fails, force reg_write_enable_out=0 and mem_write_enable_out=0. The instruction still flows.
  - Flags update only if the condition passes and set_flags_in=1.
- When nothing is accepted and there is no stall: valid_out<=0 and both write enables <=0. Data outputs may hold their previous values.
- When stalled (ex_stall_out=1): all outputs and flags hold; valid_in is ignored.

## Timing
- Latency: one cycle from acceptance to the EX/MEM outputs.
- Back-to-back flag use is supported. A flag-setting instruction accepted at edge k is visible to the condition of the instruction accepted at edge k+1, because the flags register updates at edge k.
- Reset (reset=0 at an edge) forces every output to 0 and flags to 0000. Reset overrides stall and acceptance in the same cycle.
- ex_stall_out depends only on registered valid_out and mem_stall_in. There is no combinational path from valid_in.
- A stall that is released at edge k lets the held instruction leave. A pending valid_in is accepted at that same edge k.

## Structure
- Shared package arm_pipe_pkg contains:
  - ALU op encodings (ALU_ADD/SUB/AND/ORR).
  - The 4-bit condition code constants.
  - NZCV bit indices (FLAG_N=3 … FLAG_V=0).
- One combinational sub-module, ex_alu, computes the result and its next N/Z/C/V. Condition evaluation and all registers stay in ex_stage.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release → all outputs are 0, flags_out=0000, ex_stall_out=0.
- ADD with flags: rd1=0x7FFFFFFF, ext_imm=1, alu_src=1, set_flags=1, cond=AL → next cycle alu_result_out=0x80000000 and flags_out=1001.
- Condition gating:
  - Setup: SUB 5−5 with set_flags=1, so Z=1 and C=1.
  - Next cycle, EQ with reg_write=1 → reg_write_enable_out=1.
  - Following cycle, NE with reg_write=1 → valid_out=1, reg_write_enable_out=0, flags unchanged.
- Logical op: set C=1 and V=1, then AND 0xF0&0x0F with set_flags → alu_result=0 and flags_out=0111.
- Stall:
  - With valid_out=1, hold mem_stall_in=1 for 3 cycles while valid_in=1 presents ADD 1+2.
  - During the stall → outputs and flags are frozen and ex_stall_out=1.
  - One cycle after release → alu_result_out=3.
- Reset mid-stall: assert reset=0 while ex_stall_out=1 → next edge valid_out=0, write enables 0, flags 0000.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline encodings: ALU ops, condition codes, NZCV bit positions.
// Also holds the condition-pass evaluation used by the execute stage.
package arm_pipe_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // The NV encoding is treated as always, matching later ARM behaviour.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, p;
      n = nzcv[FLAG_N];
      z = nzcv[FLAG_Z];
      c = nzcv[FLAG_C];
      v = nzcv[FLAG_V];
      case (cond)
         COND_EQ: p = z;
         COND_NE: p = !z;
         COND_CS: p = c;
         COND_CC: p = !c;
         COND_MI: p = n;
         COND_PL: p = !n;
         COND_VS: p = v;
         COND_VC: p = !v;
         COND_HI: p = c & !z;
         COND_LS: p = !c | z;
         COND_GE: p = (n == v);
         COND_LT: p = (n != v);
         COND_GT: p = !z & (n == v);
         COND_LE: p = z | (n != v);
         default: p = 1'b1;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational 2-bit-op ALU with next NZCV; logical ops carry C and V through.
// Zero latency, no flow control.
module ex_alu
   import arm_pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [1:0]        op_i,
   input  logic [3:0]        flags_i,
   output logic [DATA_W-1:0] result_o,
   output logic [3:0]        flags_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;
   logic            c_flag;
   logic            v_flag;
   logic            a_msb, b_msb, r_msb;

   assign sum   = {1'b0, a_i} + {1'b0, b_i};
   assign diff  = {1'b0, a_i} - {1'b0, b_i};
   assign a_msb = a_i[DATA_W-1];
   assign b_msb = b_i[DATA_W-1];
   assign r_msb = result_o[DATA_W-1];

   always_comb begin
      result_o = sum[DATA_W-1:0];
      c_flag   = flags_i[FLAG_C];
      v_flag   = flags_i[FLAG_V];
      case (op_i)
         ALU_ADD: begin
            result_o = sum[DATA_W-1:0];
            c_flag   = sum[DATA_W];
            v_flag   = (a_msb == b_msb) && (sum[DATA_W-1] != a_msb);
         end
         ALU_SUB: begin
            // Borrow shows up in the extra top bit; ARM C is its inverse.
            result_o = diff[DATA_W-1:0];
            c_flag   = ~diff[DATA_W];
            v_flag   = (a_msb != b_msb) && (diff[DATA_W-1] != a_msb);
         end
         ALU_AND: result_o = a_i & b_i;
         default: result_o = a_i | b_i;
      endcase
   end

   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_N] = r_msb;
      flags_o[FLAG_Z] = (result_o == '0);
      flags_o[FLAG_C] = c_flag;
      flags_o[FLAG_V] = v_flag;
   end

endmodule

// File: rtl/ex_stage.sv
// ARM execute stage: operand select, ALU, condition check, NZCV, EX/MEM register; 1-cycle latency.
// mem_stall_in with a valid EX/MEM entry freezes all state and raises ex_stall_out to hold ID/EX.
module ex_stage
   import arm_pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic                  reg_write_enable_in,
   input  logic                  mem_write_enable_in,
   input  logic                  mem_to_reg_select_in,
   input  logic                  alu_src_select_in,
   input  logic [1:0]            alu_control_in,
   input  logic                  set_flags_in,
   input  logic [3:0]            cond_in,
   input  logic [DATA_W-1:0]     rd1_in,
   input  logic [DATA_W-1:0]     rd2_in,
   input  logic [DATA_W-1:0]     ext_imm_in,
   input  logic [REG_ADDR_W-1:0] write_addr_in,
   input  logic                  mem_stall_in,
   output logic                  ex_stall_out,
   output logic                  valid_out,
   output logic                  reg_write_enable_out,
   output logic                  mem_write_enable_out,
   output logic                  mem_to_reg_select_out,
   output logic [DATA_W-1:0]     alu_result_out,
   output logic [DATA_W-1:0]     write_data_out,
   output logic [REG_ADDR_W-1:0] write_addr_out,
   output logic [3:0]            flags_out
);

   logic                  valid_q, valid_d;
   logic                  rwe_q, rwe_d;
   logic                  mwe_q, mwe_d;
   logic                  m2r_q, m2r_d;
   logic [DATA_W-1:0]     alu_q, alu_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [3:0]            flags_q, flags_d;

   logic [DATA_W-1:0]     op_b;
   logic [DATA_W-1:0]     alu_res;
   logic [3:0]            alu_flags;
   logic                  accept;
   logic                  pass;

   assign ex_stall_out = valid_q & mem_stall_in;
   assign accept       = valid_in & ~ex_stall_out;
   assign op_b         = alu_src_select_in ? ext_imm_in : rd2_in;
   assign pass         = cond_pass(cond_in, flags_q);

   ex_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (rd1_in),
      .b_i      (op_b),
      .op_i     (alu_control_in),
      .flags_i  (flags_q),
      .result_o (alu_res),
      .flags_o  (alu_flags)
   );

   always_comb begin
      valid_d = valid_q;
      rwe_d   = rwe_q;
      mwe_d   = mwe_q;
      m2r_d   = m2r_q;
      alu_d   = alu_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      flags_d = flags_q;
      if (accept) begin
         valid_d = 1'b1;
         rwe_d   = reg_write_enable_in & pass;
         mwe_d   = mem_write_enable_in & pass;
         m2r_d   = mem_to_reg_select_in;
         alu_d   = alu_res;
         wdata_d = rd2_in;
         waddr_d = write_addr_in;
         if (pass && set_flags_in) flags_d = alu_flags;
      end else if (!ex_stall_out) begin
         // Bubble: data fields keep stale values, only valid and enables drop.
         valid_d = 1'b0;
         rwe_d   = 1'b0;
         mwe_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         rwe_q   <= 1'b0;
         mwe_q   <= 1'b0;
         m2r_q   <= 1'b0;
         alu_q   <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
         flags_q <= '0;
      end else begin
         valid_q <= valid_d;
         rwe_q   <= rwe_d;
         mwe_q   <= mwe_d;
         m2r_q   <= m2r_d;
         alu_q   <= alu_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         flags_q <= flags_d;
      end
   end

   assign valid_out             = valid_q;
   assign reg_write_enable_out  = rwe_q;
   assign mem_write_enable_out  = mwe_q;
   assign mem_to_reg_select_out = m2r_q;
   assign alu_result_out        = alu_q;
   assign write_data_out        = wdata_q;
   assign write_addr_out        = waddr_q;
   assign flags_out             = flags_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a reference model queues expected EX/MEM contents as
// instructions are driven; each scenario task pops and compares when the stage produces output.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in, rwe_in, mwe_in, m2r_in, src_in, sf_in, mem_stall_in;
   logic [1:0]  alu_ctl_in;
   logic [3:0]  cond_in;
   logic [31:0] rd1_in, rd2_in, imm_in;
   logic [3:0]  waddr_in;
   logic        ex_stall_out, valid_out, rwe_out, mwe_out, m2r_out;
   logic [31:0] alu_result_out, write_data_out;
   logic [3:0]  write_addr_out, flags_out;

   typedef struct packed {
      logic [31:0] res;
      logic        rwe;
      logic        mwe;
      logic        m2r;
      logic [31:0] wdata;
      logic [3:0]  waddr;
      logic [3:0]  flags;
   } exp_t;

   exp_t       scb[$];
   logic [3:0] m_flags;
   int         tests_run = 0;
   int         tests_failed = 0;

   always #5 clk = ~clk;

   ex_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .valid_in              (valid_in),
      .reg_write_enable_in   (rwe_in),
      .mem_write_enable_in   (mwe_in),
      .mem_to_reg_select_in  (m2r_in),
      .alu_src_select_in     (src_in),
      .alu_control_in        (alu_ctl_in),
      .set_flags_in          (sf_in),
      .cond_in               (cond_in),
      .rd1_in                (rd1_in),
      .rd2_in                (rd2_in),
      .ext_imm_in            (imm_in),
      .write_addr_in         (waddr_in),
      .mem_stall_in          (mem_stall_in),
      .ex_stall_out          (ex_stall_out),
      .valid_out             (valid_out),
      .reg_write_enable_out  (rwe_out),
      .mem_write_enable_out  (mwe_out),
      .mem_to_reg_select_out (m2r_out),
      .alu_result_out        (alu_result_out),
      .write_data_out        (write_data_out),
      .write_addr_out        (write_addr_out),
      .flags_out             (flags_out)
   );

   function automatic bit m_pass(input logic [3:0] cond, input logic [3:0] f);
      bit n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      valid_in = 0; rwe_in = 0; mwe_in = 0; m2r_in = 0; src_in = 0; sf_in = 0;
      alu_ctl_in = 0; cond_in = 4'hE; rd1_in = 0; rd2_in = 0; imm_in = 0; waddr_in = 0;
   endtask

   // Drive one instruction and queue what the EX/MEM register must hold once it is accepted.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit src, input bit sf, input bit rw,
                        input bit mw, input bit m2r, input logic [3:0] cond, input logic [3:0] wa);
      logic [63:0] ua;
      longint      sd;
      logic [31:0] bop, r;
      bit          cf, vf, p;
      exp_t        e;
      bop = src ? imm : b;
      cf = m_flags[1]; vf = m_flags[0];
      case (op)
         2'd0: begin
            ua = 64'(a) + 64'(bop);
            r  = ua[31:0];
            cf = ua[32];
            sd = longint'($signed(a)) + longint'($signed(bop));
            vf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
         end
         2'd1: begin
            r  = a - bop;
            cf = (a >= bop);
            sd = longint'($signed(a)) - longint'($signed(bop));
            vf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
         end
         2'd2:    r = a & bop;
         default: r = a | bop;
      endcase
      p = m_pass(cond, m_flags);
      if (p && sf) m_flags = {r[31], (r == 32'd0), cf, vf};
      e.res = r; e.rwe = rw && p; e.mwe = mw && p; e.m2r = m2r;
      e.wdata = b; e.waddr = wa; e.flags = m_flags;
      scb.push_back(e);
      valid_in = 1; alu_ctl_in = op; rd1_in = a; rd2_in = b; imm_in = imm; src_in = src;
      sf_in = sf; rwe_in = rw; mwe_in = mw; m2r_in = m2r; cond_in = cond; waddr_in = wa;
   endtask

   function automatic exp_t pop_exp(input string name);
      if (scb.size() == 0) begin
         tests_run++; tests_failed++;
         $display("FAIL %s: scoreboard empty when output expected", name);
         return '0;
      end
      return scb.pop_front();
   endfunction

   task automatic test_reset();
      reset = 0; mem_stall_in = 0; idle();
      tick(); tick();
      reset = 1;
      #1;
      tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      tests_run++; if (flags_out !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", flags_out); end
      tests_run++; if (ex_stall_out !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", ex_stall_out); end
      tests_run++;
      if ({rwe_out, mwe_out, m2r_out, alu_result_out, write_data_out, write_addr_out} !== '0) begin
         tests_failed++; $display("FAIL reset_outputs: got %h %h %h %b%b%b want all zero",
                                  alu_result_out, write_data_out, write_addr_out, rwe_out, mwe_out, m2r_out);
      end
      m_flags = 4'b0000;
   endtask

   task automatic test_add_flags();
      exp_t e;
      @(negedge clk);
      issue(2'd0, 32'h7FFF_FFFF, 32'h0000_00AA, 32'h1, 1, 1, 1, 0, 0, 4'hE, 4'd3);
      tick(); idle();
      e = pop_exp("add");
      tests_run++; if (alu_result_out !== e.res || e.res !== 32'h8000_0000) begin tests_failed++; $display("FAIL add_result: got %h want %h", alu_result_out, e.res); end
      tests_run++; if (flags_out !== e.flags || e.flags !== 4'b1001) begin tests_failed++; $display("FAIL add_flags: got %b want %b", flags_out, e.flags); end
      tests_run++; if (write_data_out !== e.wdata || write_addr_out !== e.waddr || rwe_out !== e.rwe) begin
         tests_failed++; $display("FAIL add_fields: got wd=%h wa=%h rwe=%b want wd=%h wa=%h rwe=%b",
                                  write_data_out, write_addr_out, rwe_out, e.wdata, e.waddr, e.rwe); end
   endtask

   task automatic test_cond_gating();
      exp_t e;
      issue(2'd1, 32'd5, 32'd5, 32'd0, 0, 1, 1, 0, 0, 4'hE, 4'd1);
      tick();
      e = pop_exp("sub_setup");
      tests_run++; if (flags_out !== e.flags || alu_result_out !== 32'd0) begin tests_failed++; $display("FAIL sub_flags: got %b/%h want %b/0", flags_out, alu_result_out, e.flags); end
      issue(2'd0, 32'd1, 32'd1, 32'd0, 0, 0, 1, 0, 1, 4'h0, 4'd2);
      tick();
      e = pop_exp("eq");
      tests_run++; if (rwe_out !== e.rwe || rwe_out !== 1'b1) begin tests_failed++; $display("FAIL eq_rwe: got %b want %b", rwe_out, e.rwe); end
      tests_run++; if (m2r_out !== e.m2r) begin tests_failed++; $display("FAIL eq_m2r: got %b want %b", m2r_out, e.m2r); end
      issue(2'd0, 32'd1, 32'd1, 32'd0, 0, 1, 1, 1, 0, 4'h1, 4'd2);
      tick(); idle();
      e = pop_exp("ne");
      tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL ne_valid: got %b want 1", valid_out); end
      tests_run++; if (rwe_out !== e.rwe || mwe_out !== e.mwe) begin tests_failed++; $display("FAIL ne_enables: got %b%b want %b%b", rwe_out, mwe_out, e.rwe, e.mwe); end
      tests_run++; if (flags_out !== e.flags) begin tests_failed++; $display("FAIL ne_flags: got %b want %b", flags_out, e.flags); end
   endtask

   task automatic test_logical();
      exp_t e;
      issue(2'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 0, 1, 0, 0, 0, 4'hE, 4'd0);
      tick();
      e = pop_exp("cv_setup");
      tests_run++; if (flags_out !== e.flags) begin tests_failed++; $display("FAIL cv_setup: got %b want %b", flags_out, e.flags); end
      issue(2'd2, 32'hF0, 32'h0F, 32'd0, 0, 1, 1, 0, 0, 4'hE, 4'd4);
      tick(); idle();
      e = pop_exp("and");
      tests_run++; if (alu_result_out !== e.res) begin tests_failed++; $display("FAIL and_result: got %h want %h", alu_result_out, e.res); end
      tests_run++; if (flags_out !== e.flags || e.flags !== 4'b0111) begin tests_failed++; $display("FAIL and_flags: got %b want %b", flags_out, e.flags); end
      tick();
      tests_run++; if (valid_out !== 1'b0 || rwe_out !== 1'b0 || mwe_out !== 1'b0) begin tests_failed++; $display("FAIL bubble: got v=%b rwe=%b mwe=%b want 000", valid_out, rwe_out, mwe_out); end
   endtask

   task automatic test_cond_sweep();
      logic [31:0] ta [0:6];
      logic [31:0] tb [0:6];
      logic [1:0]  to [0:6];
      exp_t        e;
      ta = '{32'd1, 32'd0, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      tb = '{32'd1, 32'd1, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
      to = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
      for (int s = 0; s < 7; s++) begin
         issue(to[s], ta[s], tb[s], 32'd0, 0, 1, 0, 0, 0, 4'hE, 4'd5);
         tick();
         e = pop_exp("sweep_setup");
         tests_run++; if (flags_out !== e.flags) begin tests_failed++; $display("FAIL sweep_flags[%0d]: got %b want %b", s, flags_out, e.flags); end
         for (int c = 0; c < 16; c++) begin
            issue(2'd3, 32'h12, 32'h21, 32'd0, 0, 0, 1, 1, 0, c[3:0], 4'd6);
            tick();
            e = pop_exp("sweep");
            tests_run++;
            if (rwe_out !== e.rwe || mwe_out !== e.mwe) begin
               tests_failed++; $display("FAIL cond[%0d] nzcv=%b: got rwe/mwe %b%b want %b%b", c, e.flags, rwe_out, mwe_out, e.rwe, e.mwe);
            end
         end
      end
      idle();
   endtask

   task automatic test_stall();
      exp_t       e;
      logic [3:0] held_flags;
      issue(2'd3, 32'h12, 32'h21, 32'd0, 0, 0, 1, 0, 0, 4'hE, 4'd7);
      tick();
      e = pop_exp("pre_stall");
      tests_run++; if (alu_result_out !== e.res || valid_out !== 1'b1) begin tests_failed++; $display("FAIL pre_stall: got %h v=%b want %h v=1", alu_result_out, valid_out, e.res); end
      held_flags = flags_out;
      mem_stall_in = 1;
      issue(2'd0, 32'd1, 32'd2, 32'd0, 0, 0, 1, 0, 0, 4'hE, 4'd8);
      #1;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (ex_stall_out !== 1'b1 || valid_out !== 1'b1 || alu_result_out !== e.res || flags_out !== held_flags || write_addr_out !== e.waddr) begin
            tests_failed++; $display("FAIL stall_hold[%0d]: got st=%b v=%b r=%h f=%b wa=%h want st=1 v=1 r=%h f=%b wa=%h",
                                     i, ex_stall_out, valid_out, alu_result_out, flags_out, write_addr_out, e.res, held_flags, e.waddr);
         end
         tick();
      end
      mem_stall_in = 0;
      tick(); idle();
      e = pop_exp("post_stall");
      tests_run++; if (alu_result_out !== e.res || e.res !== 32'd3 || write_addr_out !== 4'd8) begin tests_failed++; $display("FAIL post_stall: got %h wa=%h want %h wa=8", alu_result_out, write_addr_out, e.res); end
      tests_run++; if (ex_stall_out !== 1'b0) begin tests_failed++; $display("FAIL post_stall_flag: got %b want 0", ex_stall_out); end
   endtask

   task automatic test_reset_mid_stall();
      exp_t e;
      issue(2'd1, 32'd3, 32'd9, 32'd0, 0, 1, 1, 1, 1, 4'hE, 4'd9);
      tick(); idle();
      e = pop_exp("pre_reset");
      tests_run++; if (flags_out !== e.flags) begin tests_failed++; $display("FAIL pre_reset_flags: got %b want %b", flags_out, e.flags); end
      mem_stall_in = 1;
      #1;
      tests_run++; if (ex_stall_out !== 1'b1) begin tests_failed++; $display("FAIL mid_stall: got %b want 1", ex_stall_out); end
      reset = 0;
      issue(2'd0, 32'd4, 32'd4, 32'd0, 0, 1, 1, 1, 0, 4'hE, 4'd1);
      void'(scb.pop_back());
      tick();
      tests_run++;
      if (valid_out !== 1'b0 || rwe_out !== 1'b0 || mwe_out !== 1'b0 || flags_out !== 4'b0000 || alu_result_out !== 32'd0) begin
         tests_failed++; $display("FAIL reset_mid_stall: got v=%b rwe=%b mwe=%b f=%b r=%h want all zero",
                                  valid_out, rwe_out, mwe_out, flags_out, alu_result_out);
      end
      reset = 1; mem_stall_in = 0; idle();
      m_flags = 4'b0000;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      m_flags = 4'b0000;
      test_reset();
      test_add_flags();
      test_cond_gating();
      test_logical();
      test_cond_sweep();
      test_stall();
      test_reset_mid_stall();
      tests_run++;
      if (scb.size() != 0) begin tests_failed++; $display("FAIL scoreboard_drain: got %0d left want 0", scb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
